// File: rtl/decode_pipe.sv
// decode_pipe: combinational RV32 base-opcode decoder feeding a small in-order
// output queue.
//
// Ports
//   clk, reset_n          single clock, asynchronous active-low reset
//   flush_i               drop every queued entry (and any same-cycle push)
//   in_valid_i/in_ready_o input handshake; in_ready_o = (count_o != DEPTH)
//   instr_i, pc_i         raw instruction word and its PC
//   out_valid_o/out_ready_i output handshake; out_valid_o = (count_o != 0)
//   rs1_o, rs2_o, rd_o    register indices of the head entry (fixed positions)
//   op_o, funct3_o, funct7_o raw fields of the head entry
//   type_o                one-hot {j,u,b,s,i,r} class of the head entry
//   imm_o                 sign-extended immediate of the head entry
//   pc_o                  PC of the head entry
//   illegal_o             head entry is an illegal encoding
//   count_o               queue occupancy
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [XLEN-1:0]            pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [4:0]                 rd_o,
  output logic [6:0]                 op_o,
  output logic [2:0]                 funct3_o,
  output logic [6:0]                 funct7_o,
  output logic [5:0]                 type_o,
  output logic [XLEN-1:0]            imm_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Entry layout: {illegal, type, imm, pc, instr}. The raw register and
  // opcode fields all sit at fixed bit positions of instr, so storing the
  // word itself is enough to reproduce them at the head.
  localparam int EW = 1 + 6 + 2 * XLEN + 32;

  // ---------------------------------------------------------------- decode
  logic [5:0]      dec_type;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  always_comb begin
    dec_type = 6'b000000;
    case (instr_i[6:0])
      7'b0110011:                         dec_type = 6'b000001; // r
      7'b0000011, 7'b0010011, 7'b1100111: dec_type = 6'b000010; // i
      7'b0100011:                         dec_type = 6'b000100; // s
      7'b1100011:                         dec_type = 6'b001000; // b
      7'b0010111, 7'b0110111:             dec_type = 6'b010000; // u
      7'b1101111:                         dec_type = 6'b100000; // j
      default:                            dec_type = 6'b000000;
    endcase

    dec_illegal = (instr_i[1:0] != 2'b11) || (dec_type == 6'b000000) ||
                  (dec_type[0] && (instr_i[31:25] != 7'b0000000) &&
                   (instr_i[31:25] != 7'b0100000));

    dec_imm32 = 32'd0;
    case (dec_type)
      6'b000010: dec_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      6'b000100: dec_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      6'b001000: dec_imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
      6'b010000: dec_imm32 = {instr_i[31:12], 12'd0};
      6'b100000: dec_imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
      default:   dec_imm32 = 32'd0;
    endcase

    // Widen to XLEN: fill with the sign, then overlay the 32-bit value.
    dec_imm        = {XLEN{dec_imm32[31]}};
    dec_imm[31:0]  = dec_imm32;

    if (dec_illegal) begin
      dec_type = 6'b000000;
      dec_imm  = '0;
    end
  end

  // ----------------------------------------------------------------- queue
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  // A flush wins over both handshakes for that edge.
  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {dec_illegal, dec_type, dec_imm, pc_i, instr_i};
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign head      = mem_q[rd_ptr_q];
  assign rs1_o     = head[19:15];
  assign rs2_o     = head[24:20];
  assign rd_o      = head[11:7];
  assign op_o      = head[6:0];
  assign funct3_o  = head[14:12];
  assign funct7_o  = head[31:25];
  assign pc_o      = head[32 +: XLEN];
  assign imm_o     = head[32 + XLEN +: XLEN];
  assign type_o    = head[32 + 2 * XLEN +: 6];
  assign illegal_o = head[EW-1];
  assign count_o   = count_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, 32: datapath width for the immediate and PC; the only legal values are 32 and 64.
REQ-002 Parameter DEPTH, 2: depth of the output queue; it is a power of two and at least 2.
REQ-003 Clocking is fixed: one clock; reset is asynchronous and active-low (ports clk and reset_n).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 flush_i  in  1  discard all queued entries.
REQ-007 in_valid_i  in  1  instruction offered.
REQ-008 in_ready_o  out  1  the block can accept an instruction.
REQ-009 instr_i  in  32  raw instruction word.
REQ-010 pc_i  in  XLEN  PC of instr_i.
REQ-011 out_valid_o  out  1  head entry valid.
REQ-012 out_ready_i  in  1  consumer accepts the head entry.
REQ-013 rs1_o/rs2_o/rd_o  out  5 each  register indices of the head entry.
REQ-014 op_o, funct3_o, funct7_o  out  7/3/7  raw fields of the head entry.
REQ-015 type_o  out  6  one-hot {j,u,b,s,i,r} class of the head entry.
REQ-016 imm_o  out  XLEN  sign-extended immediate of the head entry.
REQ-017 pc_o  out  XLEN  PC of the head entry.
REQ-018 illegal_o  out  1  head entry is an illegal encoding.
REQ-019 count_o  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 Accept: an instruction is accepted when in_valid_i and in_ready_o are both high; in_ready_o SHALL equal (count_o != DEPTH).
REQ-021 Decode: decoding SHALL be combinational on instr_i, and the decoded fields plus pc_i SHALL be written to the queue tail on accept.
REQ-022 Latency: an entry accepted in cycle N SHALL appear at the head no earlier than cycle N+1; with an empty queue it SHALL appear exactly at N+1.
REQ-023 Pop: the head SHALL be removed when out_valid_o and out_ready_i are both high, and out_valid_o SHALL equal (count_o != 0).
REQ-024 Payload stability: head payload outputs SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-025 Ordering: entries SHALL leave the queue strictly in acceptance order.
REQ-026 Simultaneous push and pop: when not full and not empty, count_o SHALL be unchanged; when empty, push-only applies.
REQ-027 Pointer wrap: read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-028 Class decode by opcode:
  - 0110011 = r
  - 0000011, 0010011, 1100111 = i
  - 0100011 = s
  - 1100011 = b
  - 0010111, 0110111 = u
  - 1101111 = j
REQ-029 Immediates SHALL be sign-extended from instr[31] to XLEN:
  - i: instr[31:20]
  - s: {instr[31:25], instr[11:7]}
  - b: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - u: {instr[31:12], 12'b0}
  - j: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - r: 0
REQ-030 Illegal encoding: an instruction is illegal if instr[1:0] != 11, or the opcode is unlisted, or it is r-class with funct7 not in {0000000, 0100000}.
REQ-031 For an illegal instruction: illegal_o=1, type_o=0, imm_o=0; raw fields and pc_o SHALL pass through unchanged.
REQ-032 Illegal entries SHALL be queued and handshaken like any other entry.
REQ-033 Flush: flush_i high at an edge SHALL set count_o=0 and reset both pointers.
  - A push in the same cycle SHALL be discarded.
  - A pop in the same cycle has no additional effect.
REQ-034 Register fields rs1_o, rs2_o, rd_o SHALL be output unconditionally from fixed bit positions, regardless of class.

Reset
REQ-035 While reset_n is low, the block SHALL immediately hold: count_o=0, out_valid_o=0, in_ready_o=1, all storage and payload outputs 0.
REQ-036 An asserting reset_n mid-transfer SHALL discard all queued entries; no partial entry may appear after release.
REQ-037 The first accept SHALL be possible on the first rising edge after reset_n rises.

Verification
REQ-038 Empty queue, accept 0xFFF00093 at cycle N -> at N+1: out_valid_o=1, type_o=000010, rd_o=1, rs1_o=0, imm_o=all ones.
REQ-039 Accept 0xFE208EE3 -> type_o=001000, rs1_o=1, rs2_o=2, imm_o=-4; then accept 0x00000000 -> illegal_o=1, type_o=0, imm_o=0.
REQ-040 XLEN=64, accept 0x12345037 then 0x80000037 -> imm_o=0x0000000012345000 then 0xFFFFFFFF80000000.
REQ-041 out_ready_i=0, offer DEPTH+1 back-to-back instructions -> in_ready_o=0 after DEPTH accepts and count_o=DEPTH; then out_ready_i=1 -> one pop per cycle, in order, and the extra instruction is accepted the cycle after the first pop.
REQ-042 Two queued entries, flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, and the pushed instruction never appears.
REQ-043 Three entries with pointers wrapped, reset_n pulled low between edges -> out_valid_o=0 and count_o=0 at once; after release, the queue is empty and the first accept appears at N+1.
